// File: rtl/dqdfp_link_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dqdfp_link_buf_pkg
// Description : Shared definitions for the dqd forward-pass link buffer.
//               Default geometry, FSM state encoding and a link-range helper.
// Revision    : 1.0  initial release
// ============================================================================
package dqdfp_link_buf_pkg;

  localparam int DEF_WIDTH        = 32;
  localparam int DEF_DECIMAL_BITS = 16;
  localparam int DEF_NUM_LINKS    = 7;
  localparam int LINK_W           = 3;
  localparam int NUM_COMP         = 6;  // AX,AY,AZ,LX,LY,LZ

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Links are numbered 1..num_links; index 0 is never a valid link.
  function automatic logic link_in_range(input logic [LINK_W-1:0] link,
                                         input int num_links);
    return (link != '0) && ({29'b0, link} <= num_links);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dqdfp_vec6_regfile.sv
`default_nettype none
// ============================================================================
// Module      : dqdfp_vec6_regfile
// Description : NUM_LINKS entries of {dv, da, df} 6-vectors.
//               One write port, two asynchronous read ports.
//               Out-of-range link indices read as zero.
// Ports       : clk                 clock
//               we, wr_link         write enable and link (1..NUM_LINKS)
//               wr_dv/wr_da/wr_df   write data
//               rd_link -> rd_dv/rd_da   "prev" operand read port
//               bp_link -> bp_df         drain read port
// Revision    : 1.0  initial release
// ============================================================================
module dqdfp_vec6_regfile
  import dqdfp_link_buf_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_LINKS = DEF_NUM_LINKS
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [LINK_W-1:0]          wr_link,
  input  logic [NUM_COMP*WIDTH-1:0]  wr_dv,
  input  logic [NUM_COMP*WIDTH-1:0]  wr_da,
  input  logic [NUM_COMP*WIDTH-1:0]  wr_df,
  input  logic [LINK_W-1:0]          rd_link,
  output logic [NUM_COMP*WIDTH-1:0]  rd_dv,
  output logic [NUM_COMP*WIDTH-1:0]  rd_da,
  input  logic [LINK_W-1:0]          bp_link,
  output logic [NUM_COMP*WIDTH-1:0]  bp_df
);

  localparam int VW = NUM_COMP * WIDTH;

  // Entry i holds link i+1. Contents are deliberately not reset.
  logic [VW-1:0] mem_dv [NUM_LINKS];
  logic [VW-1:0] mem_da [NUM_LINKS];
  logic [VW-1:0] mem_df [NUM_LINKS];

  for (genvar i = 0; i < NUM_LINKS; i++) begin : g_entry
    always_ff @(posedge clk) begin
      if (we && (wr_link == LINK_W'(i + 1))) begin
        mem_dv[i] <= wr_dv;
        mem_da[i] <= wr_da;
        mem_df[i] <= wr_df;
      end
    end
  end

  always_comb begin
    rd_dv = '0;
    rd_da = '0;
    bp_df = '0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      if (rd_link == LINK_W'(i + 1)) begin
        rd_dv = mem_dv[i];
        rd_da = mem_da[i];
      end
      if (bp_link == LINK_W'(i + 1)) begin
        bp_df = mem_df[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dqdfp_link_buf.sv
`default_nettype none
// ============================================================================
// Module      : dqdfp_link_buf
// Description : Per-link result buffer behind the dqd forward-pass link
//               stage. Captures dv/da/df 6-vectors for links 1..NUM_LINKS,
//               serves dv/da of a parent link with 1-cycle latency (with
//               write->read bypass), and once every link is written drains
//               df in order NUM_LINKS..1 over a valid/ready handshake.
// Ports       : clk, reset (sync, active-high), start
//               wr_valid, wr_link, wr_dv, wr_da, wr_df   write side
//               rd_en, rd_link -> rd_valid, rd_dv, rd_da read side
//               bp_valid, bp_ready, bp_link, bp_df       drain side
//               busy (FILL or DRAIN), err (sticky)
// Options     : DQDFP_LINK_BUF_DUPCHK_EN - when defined, a second write to
//               an already-written link in the same pass is dropped and
//               raises err; otherwise it silently overwrites.
// Revision    : 1.0  initial release
// ============================================================================
module dqdfp_link_buf
  import dqdfp_link_buf_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DECIMAL_BITS = DEF_DECIMAL_BITS,
  parameter int NUM_LINKS    = DEF_NUM_LINKS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       wr_valid,
  input  logic [LINK_W-1:0]          wr_link,
  input  logic [NUM_COMP*WIDTH-1:0]  wr_dv,
  input  logic [NUM_COMP*WIDTH-1:0]  wr_da,
  input  logic [NUM_COMP*WIDTH-1:0]  wr_df,
  input  logic                       rd_en,
  input  logic [LINK_W-1:0]          rd_link,
  output logic                       rd_valid,
  output logic [NUM_COMP*WIDTH-1:0]  rd_dv,
  output logic [NUM_COMP*WIDTH-1:0]  rd_da,
  output logic                       bp_valid,
  input  logic                       bp_ready,
  output logic [LINK_W-1:0]          bp_link,
  output logic [NUM_COMP*WIDTH-1:0]  bp_df,
  output logic                       busy,
  output logic                       err
);

  localparam int VW = NUM_COMP * WIDTH;

  // Data is fixed-point pass-through; the fraction width only has to fit.
  if ((NUM_LINKS < 1) || (NUM_LINKS > 7) || (DECIMAL_BITS >= WIDTH)) begin : g_bad_params
    $error("dqdfp_link_buf: illegal parameter combination");
  end

  state_t                state, state_nxt;
  logic [NUM_LINKS-1:0]  written;      // bit i set once link i+1 is captured
  logic [LINK_W-1:0]     bp_cnt;       // current drain link, 0 when not draining
  logic                  wr_legal;
  logic                  we;
  logic                  dup;
  logic                  err_set;
  logic                  start_acc;
  logic                  bp_acc;
  logic [VW-1:0]         rf_rd_dv, rf_rd_da;

  assign wr_legal  = link_in_range(wr_link, NUM_LINKS);
  assign start_acc = start && (state == IDLE);
  assign bp_valid  = (state == DRAIN);
  assign bp_acc    = bp_valid && bp_ready;
  assign bp_link   = bp_cnt;
  assign busy      = (state != IDLE);

`ifdef DQDFP_LINK_BUF_DUPCHK_EN
  logic wr_hit;
  always_comb begin
    wr_hit = 1'b0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      if (wr_link == LINK_W'(i + 1)) wr_hit = written[i];
    end
  end
  // First value of the pass wins; the rewrite is flagged and discarded.
  assign dup = wr_valid && (state == FILL) && wr_legal && wr_hit;
  assign we  = wr_valid && (state == FILL) && wr_legal && !wr_hit;
`else
  assign dup = 1'b0;
  assign we  = wr_valid && (state == FILL) && wr_legal;
`endif

  assign err_set = (wr_valid && ((state != FILL) || !wr_legal)) || dup;

  dqdfp_vec6_regfile #(
    .WIDTH     (WIDTH),
    .NUM_LINKS (NUM_LINKS)
  ) u_regfile (
    .clk     (clk),
    .we      (we),
    .wr_link (wr_link),
    .wr_dv   (wr_dv),
    .wr_da   (wr_da),
    .wr_df   (wr_df),
    .rd_link (rd_link),
    .rd_dv   (rf_rd_dv),
    .rd_da   (rf_rd_da),
    .bp_link (bp_cnt),
    .bp_df   (bp_df)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)                       state_nxt = FILL;
      FILL:    if (&written)                    state_nxt = DRAIN;
      DRAIN:   if (bp_acc && (bp_cnt == 3'd1))  state_nxt = IDLE;
      default:                                  state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Flags, drain counter, error and read port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      written  <= '0;
      bp_cnt   <= '0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      rd_dv    <= '0;
      rd_da    <= '0;
    end else begin
      if (start_acc) begin
        written <= '0;
      end else begin
        for (int i = 0; i < NUM_LINKS; i++) begin
          if (we && (wr_link == LINK_W'(i + 1))) written[i] <= 1'b1;
        end
      end

      // Counter loads on FILL->DRAIN and reaches 0 as link 1 is accepted.
      if ((state == FILL) && (state_nxt == DRAIN)) bp_cnt <= LINK_W'(NUM_LINKS);
      else if (bp_acc)                            bp_cnt <= bp_cnt - 3'd1;

      // A new error in the clearing cycle still wins, so nothing is lost.
      if (start_acc) err <= err_set;
      else           err <= err | err_set;

      rd_valid <= rd_en;
      if (rd_en) begin
        // A write landing this cycle is not yet visible in the regfile.
        if (we && (wr_link == rd_link)) begin
          rd_dv <= wr_dv;
          rd_da <= wr_da;
        end else begin
          rd_dv <= rf_rd_dv;
          rd_da <= rf_rd_da;
        end
      end
    end
  end

endmodule
`default_nettype wire
